// File: rtl/draw_text_box_pkg.sv
// Shared VGA widths, colour constants, overlay configuration type and frame-start detection
// for the text-overlay stage.
package draw_text_box_pkg;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned CNT_W = 11;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_WHITE = 12'hFFF;

  typedef enum logic {
    PH0 = 1'b0,
    PH1 = 1'b1
  } blink_ph_e;

  typedef struct packed {
    logic en;
    rgb_t fg;
    rgb_t bg;
    logic bg_transp;
    logic cursor_en;
  } ovl_cfg_t;

  function automatic logic is_frame_start(input cnt_t h, input cnt_t v);
    return (h == '0) && (v == '0);
  endfunction

endpackage

// File: rtl/draw_text_box_delay.sv
// Fixed-length register delay line.
// Cleared on reset so a refilling pipeline only ever carries zeros.
module draw_text_box_delay #(
  parameter int unsigned WIDTH   = 34,
  parameter int unsigned CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CLK_DEL; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= din;
      for (int unsigned i = 1; i < CLK_DEL; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_text_box.sv
// Text overlay stage: COLS x ROWS character grid with frame-shadowed colours, blinking cursor and
// optional one-pixel border. Glyph addresses go out one cycle after the counts; pixels LAT+1 after.
module draw_text_box
  import draw_text_box_pkg::*;
#(
  parameter int unsigned TEXT_X       = 140,
  parameter int unsigned TEXT_Y       = 464,
  parameter int unsigned COLS         = 30,
  parameter int unsigned ROWS         = 1,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned CHAR_H       = 16,
  parameter int unsigned LAT          = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter bit          BORDER_EN    = 1'b1,
  parameter rgb_t        BORDER_RGB   = RGB_WHITE,
  localparam int unsigned CW = (COLS > 1)   ? $clog2(COLS)   : 1,
  localparam int unsigned RW = (ROWS > 1)   ? $clog2(ROWS)   : 1,
  localparam int unsigned LW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic [11:0]       rgb_in,
  input  logic              en,
  input  logic [11:0]       fg_rgb,
  input  logic [11:0]       bg_rgb,
  input  logic              bg_transp,
  input  logic              cursor_en,
  input  logic [CW-1:0]     cursor_col,
  input  logic [RW-1:0]     cursor_row,
  input  logic [CHAR_W-1:0] char_pixels,
  output logic [RW+CW-1:0]  char_xy,
  output logic [LW-1:0]     char_line,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic [11:0]       rgb_out
);

  localparam int unsigned XB = $clog2(CHAR_W);
  localparam int unsigned YB = $clog2(CHAR_H);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DW = 2 * CNT_W + RGB_W;

  localparam cnt_t X_LO = cnt_t'(TEXT_X);
  localparam cnt_t X_HI = cnt_t'(TEXT_X + COLS * CHAR_W);
  localparam cnt_t Y_LO = cnt_t'(TEXT_Y);
  localparam cnt_t Y_HI = cnt_t'(TEXT_Y + ROWS * CHAR_H);
  localparam cnt_t X_BL = cnt_t'(TEXT_X - 1);
  localparam cnt_t Y_BT = cnt_t'(TEXT_Y - 1);

  logic frame_start;
  assign frame_start = is_frame_start(hcount_in, vcount_in);

  // ---------------------------------------------------------------- address stage
  logic [RW+CW-1:0] char_xy_q, char_xy_d;
  logic [LW-1:0]    char_line_q, char_line_d;
  logic             a_inside;
  cnt_t             a_hoff, a_voff;

  always_comb begin
    a_inside    = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                  (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    a_hoff      = hcount_in - X_LO;
    a_voff      = vcount_in - Y_LO;
    char_xy_d   = char_xy_q;
    char_line_d = char_line_q;
    if (a_inside) begin
      char_xy_d   = {RW'(a_voff >> YB), CW'(a_hoff >> XB)};
      char_line_d = LW'(a_voff);
    end
  end

  // ---------------------------------------------------------------- shadow registers
  ovl_cfg_t      cfg_q, cfg_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] cur_row_q, cur_row_d;

  always_comb begin
    cfg_d     = cfg_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    if (frame_start) begin
      cfg_d.en        = en;
      cfg_d.fg        = fg_rgb;
      cfg_d.bg        = bg_rgb;
      cfg_d.bg_transp = bg_transp;
      cfg_d.cursor_en = cursor_en;
      cur_col_d       = cursor_col;
      cur_row_d       = cursor_row;
    end
  end

  // ---------------------------------------------------------------- blink counter / phase FSM
  blink_ph_e     ph_q, ph_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    ph_d        = ph_q;
    blink_cnt_d = blink_cnt_q;
    if (frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        ph_d        = (ph_q == PH0) ? PH1 : PH0;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- count/colour delay line
  logic [DW-1:0] dl_out;
  cnt_t          hd, vd;
  rgb_t          rgb_dl;

  draw_text_box_delay #(
    .WIDTH  (DW),
    .CLK_DEL(LAT)
  ) u_delay (
    .clk (pclk),
    .rst (rst),
    .din ({hcount_in, vcount_in, rgb_in}),
    .dout(dl_out)
  );

  assign {hd, vd, rgb_dl} = dl_out;

  // ---------------------------------------------------------------- compose
  logic          c_inside, c_ring, c_bit, c_cursor;
  cnt_t          c_hoff, c_voff;
  logic [XB-1:0] c_xbit;
  rgb_t          rgb_out_d;

  // Range compares use the raw counts so offsets left of/above the area never wrap into it.
  always_comb begin
    c_hoff   = hd - X_LO;
    c_voff   = vd - Y_LO;
    c_inside = (hd >= X_LO) && (hd < X_HI) && (vd >= Y_LO) && (vd < Y_HI);
    c_ring   = (hd >= X_BL) && (hd <= X_HI) && (vd >= Y_BT) && (vd <= Y_HI) &&
               ((hd == X_BL) || (hd == X_HI) || (vd == Y_BT) || (vd == Y_HI));
    c_xbit   = XB'(CHAR_W - 1) - c_hoff[XB-1:0];
    c_cursor = cfg_q.cursor_en && (ph_q == PH1) &&
               (CW'(c_hoff >> XB) == cur_col_q) && (RW'(c_voff >> YB) == cur_row_q);
    c_bit    = char_pixels[c_xbit] ^ c_cursor;

    rgb_out_d = rgb_dl;
    if (cfg_q.en) begin
      if (c_inside) begin
        rgb_out_d = c_bit ? cfg_q.fg : (cfg_q.bg_transp ? rgb_dl : cfg_q.bg);
      end else if (BORDER_EN && c_ring) begin
        rgb_out_d = BORDER_RGB;
      end
    end
  end

  // ---------------------------------------------------------------- registers
  cnt_t hcount_out_q, vcount_out_q;
  rgb_t rgb_out_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      char_xy_q    <= '0;
      char_line_q  <= '0;
      cfg_q        <= '0;
      cur_col_q    <= '0;
      cur_row_q    <= '0;
      ph_q         <= PH0;
      blink_cnt_q  <= '0;
      hcount_out_q <= '0;
      vcount_out_q <= '0;
      rgb_out_q    <= RGB_BLACK;
    end else begin
      char_xy_q    <= char_xy_d;
      char_line_q  <= char_line_d;
      cfg_q        <= cfg_d;
      cur_col_q    <= cur_col_d;
      cur_row_q    <= cur_row_d;
      ph_q         <= ph_d;
      blink_cnt_q  <= blink_cnt_d;
      hcount_out_q <= hd;
      vcount_out_q <= vd;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign char_xy    = char_xy_q;
  assign char_line  = char_line_q;
  assign hcount_out = hcount_out_q;
  assign vcount_out = vcount_out_q;
  assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_draw_text_box.sv
// Scoreboarded random bench for draw_text_box: a pixel-level reference model predicts each output,
// a negedge monitor retires predictions as the pipeline presents them.
module tb_draw_text_box;
  import draw_text_box_pkg::*;

  localparam int TX   = 140;
  localparam int TY   = 464;
  localparam int NC   = 30;
  localparam int GW   = 8;
  localparam int GH   = 16;
  localparam int BF   = 2;
  localparam int PIPE = 3;
  localparam int XR   = TX + NC * GW;
  localparam int YE   = TY + GH;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic [11:0] rgb_in, fg_rgb, bg_rgb, rgb_out;
  logic        en, bg_transp, cursor_en;
  logic [4:0]  cursor_col;
  logic [0:0]  cursor_row;
  logic [7:0]  char_pixels;
  logic [5:0]  char_xy;
  logic [3:0]  char_line;

  always #5 pclk = ~pclk;

  draw_text_box #(
    .TEXT_X(140), .TEXT_Y(464), .COLS(30), .ROWS(1), .CHAR_W(8), .CHAR_H(16),
    .LAT(2), .BLINK_FRAMES(2), .BORDER_EN(1'b1), .BORDER_RGB(12'hFFF)
  ) dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in), .rgb_in(rgb_in),
    .en(en), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .bg_transp(bg_transp), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .char_pixels(char_pixels),
    .char_xy(char_xy), .char_line(char_line), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .rgb_out(rgb_out)
  );

  // Character RAM + font ROM stand-in: one registered lookup after the DUT's address register.
  logic [7:0] glyph [32][16];
  always @(posedge pclk) char_pixels <= glyph[char_xy[4:0]][char_line];

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned t;
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] rgb;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_off = 1'b0;
  bit   use_fix = 1'b0;
  logic [11:0] fix_rgb = 12'h123;

  // Reference state: what the overlay should be using this frame.
  logic        m_en, m_transp, m_cen;
  logic [11:0] m_fg, m_bg;
  int          m_ccol, m_crow, m_fs;

  function automatic logic [11:0] ref_pix(input int x, input int y, input logic [11:0] rin);
    int col, row, line;
    logic [7:0] g;
    logic b;
    if (!m_en) return rin;
    if (x >= TX && x < XR && y >= TY && y < YE) begin
      col  = (x - TX) / GW;
      row  = (y - TY) / GH;
      line = (y - TY) % GH;
      g    = glyph[col][line];
      b    = g[GW - 1 - ((x - TX) % GW)];
      if (m_cen && ((m_fs / BF) % 2 == 1) && col == m_ccol && row == m_crow) b = ~b;
      return b ? m_fg : (m_transp ? rin : m_bg);
    end
    if (x >= TX - 1 && x <= XR && y >= TY - 1 && y <= YE &&
        (x == TX - 1 || x == XR || y == TY - 1 || y == YE)) return 12'hFFF;
    return rin;
  endfunction

  task automatic model_reset();
    m_en = 0; m_transp = 0; m_cen = 0; m_fg = '0; m_bg = '0; m_ccol = 0; m_crow = 0; m_fs = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at posedge+1; applies one pixel and predicts its output.
  task automatic drive(input int x, input int y);
    exp_t e;
    hcount_in = 11'(x);
    vcount_in = 11'(y);
    rgb_in    = use_fix ? fix_rgb : 12'($urandom);
    if (x == 0 && y == 0) begin
      m_en = en; m_fg = fg_rgb; m_bg = bg_rgb; m_transp = bg_transp; m_cen = cursor_en;
      m_ccol = int'(cursor_col); m_crow = int'(cursor_row); m_fs++;
    end
    e.t = cyc; e.h = 11'(x); e.v = 11'(y); e.rgb = ref_pix(x, y, rgb_in);
    sbq.push_back(e);
    @(posedge pclk); #1;
  endtask

  task automatic set_cfg(input logic e, input logic [11:0] fg, input logic [11:0] bg,
                         input logic tr, input logic ce, input int cc, input int cr);
    en = e; fg_rgb = fg; bg_rgb = bg; bg_transp = tr; cursor_en = ce;
    cursor_col = 5'(cc); cursor_row = 1'(cr);
  endtask

  task automatic scramble_inputs();
    set_cfg(1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 31), $urandom_range(0, 1));
  endtask

  task automatic frame_start();
    for (int i = 0; i < 4; i++) drive(799 - i, 524);
    drive(0, 0);
    drive(1, 0);
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) drive(x, y);
  endtask

  task automatic scan_frame(input bit mid_change);
    scan(TY - 1, TX - 4, XR + 4);
    if (mid_change) scramble_inputs();
    scan(TY, TX - 4, XR + 4);
    scan(TY + 1, TX - 4, XR + 4);
    scan($urandom_range(TY + 2, YE - 2), TX - 4, XR + 4);
    scan($urandom_range(TY + 2, YE - 2), TX - 4, XR + 4);
    scan(YE - 1, TX - 4, XR + 4);
    scan(YE, TX - 4, XR + 4);
    scan(YE + 1, TX - 4, XR + 4);
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (!mon_off) begin
      while (sbq.size() > 0 && sbq[0].t + PIPE < cyc) begin
        e = sbq.pop_front();
        checks++; errors++;
        $display("FAIL overdue pixel(%0d,%0d): issued cycle %0d, now %0d", e.h, e.v, e.t, cyc);
      end
      if (sbq.size() > 0 && sbq[0].t + PIPE == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (hcount_out !== e.h || vcount_out !== e.v || rgb_out !== e.rgb) begin
          errors++;
          $display("FAIL pixel(%0d,%0d): got h=%0d v=%0d rgb=%h expected h=%0d v=%0d rgb=%h",
                   e.h, e.v, hcount_out, vcount_out, rgb_out, e.h, e.v, e.rgb);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    hcount_in = 11'd799; vcount_in = 11'd524; rgb_in = '0;
    set_cfg(0, '0, '0, 0, 0, 0, 0);
    for (int c = 0; c < 32; c++)
      for (int l = 0; l < 16; l++) glyph[c][l] = 8'($urandom);
    glyph[0][0] = 8'hA5;
    model_reset();

    repeat (3) @(posedge pclk); #1;
    chk("reset rgb_out", 32'(rgb_out), 32'h0);
    chk("reset hcount_out", 32'(hcount_out), 32'h0);
    chk("reset vcount_out", 32'(vcount_out), 32'h0);
    chk("reset char_xy", 32'(char_xy), 32'h0);
    chk("reset char_line", 32'(char_line), 32'h0);
    #2 rst = 1'b0;
    @(posedge pclk); #1;

    // Before any frame start the overlay is off regardless of en.
    set_cfg(1, 12'hFFF, 12'h000, 0, 1, 0, 0);
    for (int y = TY - 1; y <= TY + 2; y++) scan(y, TX - 4, XR + 4);

    set_cfg(1, 12'hFFF, 12'h000, 0, 0, 0, 0);
    frame_start();
    scan_frame(1'b0);

    use_fix = 1'b1;
    set_cfg(1, 12'hFFF, 12'h000, 1, 1, 3, 0);
    frame_start();
    scan_frame(1'b0);
    use_fix = 1'b0;

    for (int f = 3; f <= 6; f++) begin
      set_cfg(1, 12'($urandom), 12'($urandom), 1'($urandom), 1, 3, 0);
      frame_start();
      scan_frame(1'b1);
    end

    for (int f = 7; f <= 9; f++) begin
      set_cfg(($urandom_range(0, 3) != 0), 12'($urandom), 12'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, 31), $urandom_range(0, 1));
      frame_start();
      scan_frame(1'b1);
    end

    // Asynchronous reset in the middle of the text area.
    set_cfg(1, 12'h0F0, 12'h00F, 0, 1, 5, 0);
    frame_start();
    for (int y = TY - 1; y < 470; y++) scan(y, TX - 4, XR + 4);
    scan(470, TX - 4, 200);
    #2;
    mon_off = 1'b1;
    rst = 1'b1;
    sbq.delete();
    model_reset();
    #1;
    chk("async reset rgb_out", 32'(rgb_out), 32'h0);
    chk("async reset hcount_out", 32'(hcount_out), 32'h0);
    chk("async reset vcount_out", 32'(vcount_out), 32'h0);
    chk("async reset char_xy", 32'(char_xy), 32'h0);
    repeat (2) @(posedge pclk);
    #3 rst = 1'b0;
    @(posedge pclk); #1;
    mon_off = 1'b0;
    scan(470, 201, XR + 4);
    for (int y = 471; y <= YE + 1; y++) scan(y, TX - 4, XR + 4);

    for (int f = 1; f <= 3; f++) begin
      set_cfg(1, 12'($urandom), 12'($urandom), 1'($urandom), 1, $urandom_range(0, 31), 0);
      frame_start();
      scan_frame(1'b1);
    end

    repeat (PIPE + 3) @(posedge pclk); #1;
    chk("scoreboard drained", 32'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
